key_press_classifier: RTL and testbench

- Per-key front end for the push-button control path: one instance per KEY[n].
- Synchronises and debounces one raw active-low DE2 push button.
- Classifies each press as short or long and emits single-cycle event pulses on state[1:0].
- The downstream key_control block consumes state[1:0] as four parallel 2-bit buses: state[0] = short press, state[1] = long press.

---
 rtl/key_press_classifier.sv | 143 ++++++++++++++
 tb/tb_key_press_classifier.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_classifier.sv
// Purpose : sync + debounce one active-low push button, classify each press as short or long.
// Latency : raw edge -> pressed in 2+DEBOUNCE_CYCLES cycles; short pulse 1 cycle after release; long pulse LONG_CYCLES after pressed rises.
// Backpressure: none; state[1:0] are free-running single-cycle event pulses, the consumer must sample every cycle.
//
// Ports:
//   CLOCK_50  in   system clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   key       in   raw button, low = pressed, asynchronous and bouncy
//   state     out  [0] short-press pulse, [1] long-press pulse, one cycle each
//   pressed   out  debounced level, high while the button is accepted as held
module key_press_classifier #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       key,
    output logic [1:0] state,
    output logic       pressed
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } fsm_t;

    logic              sync1_q;
    logic              sync2_q;
    logic              deb_q;
    logic              deb_d;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_d;
    logic              pressed_q;
    fsm_t              fsm_q;
    fsm_t              fsm_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              deb_fall;

    // Two-flop synchroniser; resets to "released" so a key held through
    // reset is seen as a fresh press once debounced.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement; any agreement
    // clears the count, so glitches shorter than DEBOUNCE_CYCLES vanish.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // pressed is registered from deb_d so it changes on the same edge as
    // the debounced level itself.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            pressed_q <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            pressed_q <= ~deb_d;
        end
    end

    // Press is taken on the edge the debounced level falls, so the hold
    // count is aligned with pressed rising; release is taken from deb_q,
    // putting the short pulse one cycle after pressed falls.
    assign deb_fall = deb_q & ~deb_d;

    always_comb begin
        fsm_d      = fsm_q;
        hold_cnt_d = hold_cnt_q;
        state_d    = 2'b00;
        case (fsm_q)
            IDLE: begin
                if (deb_fall) begin
                    fsm_d      = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                // Release is tested first so it wins a tie with the threshold.
                if (deb_q) begin
                    state_d = 2'b01;
                    fsm_d   = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = 2'b10;
                    fsm_d   = LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            LONG: begin
                if (deb_q) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            hold_cnt_q <= '0;
            state_q    <= 2'b00;
        end else begin
            fsm_q      <= fsm_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
        end
    end

    assign state   = state_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_key_press_classifier.sv
module tb_key_press_classifier;

    localparam int D = 4;
    localparam int L = 20;

    logic       CLOCK_50;
    logic       rst_n;
    logic       key;
    logic [1:0] state;
    logic       pressed;

    key_press_classifier #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst_n   (rst_n),
        .key     (key),
        .state   (state),
        .pressed (pressed)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Reference model: edge count since reset release, raw key samples per edge.
    int         n;
    int         raw[$];
    int         deb_m;
    int         press_start;
    int         exp_short;
    int         exp_long;
    logic       exp_pressed;
    logic [1:0] exp_state;

    // Observed event bookkeeping.
    logic prev_pressed;
    int   rise_edge, fall_edge, short_edge, long_edge;
    int   short_cnt, long_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int raw_at(input int i);
        if (i < 1) return 1;
        return raw[i];
    endfunction

    task automatic model_reset();
        n = 0;
        raw.delete();
        raw.push_back(1);
        deb_m       = 1;
        press_start = -1;
        exp_short   = -1;
        exp_long    = -1;
        exp_pressed = 1'b0;
        exp_state   = 2'b00;
    endtask

    // The debounced level takes a new value once the raw key has held that
    // value for D consecutive samples, seen two edges late. A press lasting
    // fewer than L debounced edges yields a short pulse one edge after
    // release; otherwise one long pulse L edges after the press began.
    task automatic model_edge(input logic k);
        bit stable;
        raw.push_back(int'(k));
        stable = 1'b1;
        for (int j = n - D - 1; j <= n - 2; j++) begin
            if (raw_at(j) == deb_m) stable = 1'b0;
        end
        if (stable) begin
            deb_m = 1 - deb_m;
            if (deb_m == 0) begin
                press_start = n;
                exp_long    = n + L;
            end else if (press_start >= 0) begin
                if (n - press_start < L) begin
                    exp_short = n + 1;
                    exp_long  = -1;
                end
                press_start = -1;
            end
        end
        exp_pressed = (deb_m == 0);
        exp_state   = {(n == exp_long), (n == exp_short)};
    endtask

    task automatic track();
        if (pressed === 1'b1 && prev_pressed === 1'b0) rise_edge = n;
        if (pressed === 1'b0 && prev_pressed === 1'b1) fall_edge = n;
        if (state[0] === 1'b1) begin short_edge = n; short_cnt++; end
        if (state[1] === 1'b1) begin long_edge = n; long_cnt++; end
        prev_pressed = pressed;
    endtask

    // One clock in normal operation: drive at negedge, model the edge,
    // compare at the next negedge.
    task automatic cyc(input logic k);
        key = k;
        @(posedge CLOCK_50);
        n++;
        model_edge(k);
        @(negedge CLOCK_50);
        check("pressed", 32'(pressed), 32'(exp_pressed));
        check("state", 32'(state), 32'(exp_state));
        track();
    endtask

    // One clock with reset held: outputs must stay zero.
    task automatic rcyc(input logic k);
        key = k;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_pressed", 32'(pressed), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        prev_pressed = pressed;
    endtask

    initial begin
        int t0, sc, lc, len;
        logic lvl;

        rst_n = 1'b1;
        key   = 1'b1;
        prev_pressed = 1'b0;
        rise_edge = -1; fall_edge = -1; short_edge = -1; long_edge = -1;
        short_cnt = 0; long_cnt = 0;
        model_reset();

        // 1. Reset with a toggling key, then quiet idle.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_state", 32'(state), 32'd0);
        check("rst_async_pressed", 32'(pressed), 32'd0);
        for (int i = 0; i < 8; i++) rcyc(1'($urandom_range(0, 1)));
        rst_n = 1'b1;
        model_reset();
        repeat (50) cyc(1'b1);
        check("idle_short_cnt", short_cnt, 0);
        check("idle_long_cnt", long_cnt, 0);

        // 2. Bounce rejection: glitches of 1..3 cycles.
        for (int g = 0; g < 10; g++) begin
            repeat ($urandom_range(1, 3)) cyc(1'b0);
            repeat ($urandom_range(4, 8)) cyc(1'b1);
        end
        check("bounce_rise", rise_edge, -1);
        check("bounce_pulses", short_cnt + long_cnt, 0);

        // 3. Short press.
        t0 = n; sc = short_cnt; lc = long_cnt;
        repeat (10) cyc(1'b0);
        repeat (20) cyc(1'b1);
        check("short_rise", rise_edge, t0 + 6);
        check("short_fall", fall_edge, t0 + 16);
        check("short_edge", short_edge, t0 + 17);
        check("short_nshort", short_cnt - sc, 1);
        check("short_nlong", long_cnt - lc, 0);

        // 4. Long press.
        t0 = n; sc = short_cnt; lc = long_cnt;
        repeat (40) cyc(1'b0);
        repeat (20) cyc(1'b1);
        check("long_rise", rise_edge, t0 + 6);
        check("long_edge", long_edge, t0 + 26);
        check("long_fall", fall_edge, t0 + 46);
        check("long_nlong", long_cnt - lc, 1);
        check("long_nshort", short_cnt - sc, 0);

        // 5. Release coincides with hold count L-1: short wins.
        t0 = n; sc = short_cnt; lc = long_cnt;
        repeat (19) cyc(1'b0);
        repeat (20) cyc(1'b1);
        check("tie_fall", fall_edge - rise_edge, 19);
        check("tie_short_edge", short_edge, t0 + 26);
        check("tie_nshort", short_cnt - sc, 1);
        check("tie_nlong", long_cnt - lc, 0);

        // 6. Reset at hold count 10, key kept low through and after reset.
        t0 = n; sc = short_cnt; lc = long_cnt;
        while (n < t0 + 16) cyc(1'b0);
        check("midhold_pressed", 32'(pressed), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midhold_async_state", 32'(state), 32'd0);
        check("midhold_async_pressed", 32'(pressed), 32'd0);
        @(negedge CLOCK_50);
        for (int i = 0; i < 3; i++) rcyc(1'b0);
        rst_n = 1'b1;
        model_reset();
        rise_edge = -1;
        repeat (30) cyc(1'b0);
        repeat (20) cyc(1'b1);
        check("rstheld_rise", rise_edge, 6);
        check("rstheld_long_edge", long_edge, 26);
        check("rstheld_nlong", long_cnt - lc, 1);
        check("rstheld_nshort", short_cnt - sc, 0);

        // 7. Random key activity checked cycle by cycle against the model.
        lvl = 1'b0;
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 28);
            repeat (len) cyc(lvl);
            lvl = ~lvl;
        end
        repeat (40) cyc(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
